keypad_fifo_ctrl: RTL and testbench
===================================

KEYPAD_FIFO_CTRL -- requirements
Module: keypad_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DEB_CYCLES, default 1000000, debounce stability window in clk cycles (10 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port key_in  input  4  key code 0x0-0xF from the matrix scanner.
REQ-006 SHALL have port key_pressed  input  1  scanner press level, 1 = key held.
REQ-007 SHALL have port cs  input  1  chip select for the keypad I/O window (0xFC10-0xFC13).
REQ-008 SHALL have port io_rd  input  1  read strobe, one cycle per access.
REQ-009 SHALL have port io_wr  input  1  write strobe, one cycle per access.
REQ-010 SHALL have port addr  input  1  register select: 0 = DATA (0xFC10), 1 = STATUS (0xFC12).
REQ-011 SHALL have port wdata  input  16  write data.
REQ-012 SHALL have port rdata  output  16  read data, combinational from addr and current state.
REQ-013 SHALL have port irq  output  1  level interrupt, 1 while FIFO non-empty.

Function
REQ-014 SHALL register key_in and key_pressed once on entry (in_code, in_press).
REQ-015 Debounce: counter resets whenever in_press equals stable_press; when it differs, counter increments; on reaching DEB_CYCLES-1, stable_press <= in_press and counter clears.
REQ-016 On stable_press 0->1 transition, the in_code captured in that same cycle SHALL be the push code.
REQ-017 Push SHALL occur exactly once per debounced press; holding a key or bouncing within the window produces no further push.
REQ-018 Pop SHALL occur on the clk edge where cs && io_rd && addr==0 and FIFO non-empty.
REQ-019 DATA read: rdata = {12'h000, head entry} when non-empty; 16'h0000 when empty, no pointer change.
REQ-020 STATUS read: rdata[0] non-empty, [1] full, [2] overflow (sticky), [7:4] count (0..DEPTH), all other bits 0; no side effects.
REQ-021 STATUS write (cs && io_wr && addr==1): wdata[0]=1 flushes FIFO (pointers and count to 0); wdata[2]=1 clears overflow; other bits ignored.
REQ-022 Writes to DATA SHALL be ignored; io_rd and io_wr together SHALL perform the read-side pop and the write effect in the same cycle.
REQ-023 Push when full without simultaneous pop: entry discarded, overflow <= 1, contents unchanged.
REQ-024 Push and pop same cycle, non-empty: both performed, count unchanged, including when full (no overflow).
REQ-025 Push and pop same cycle, empty: push performed, pop ignored, rdata = 0.
REQ-026 Flush and push same cycle: flush wins, key dropped, overflow not set.
REQ-027 Pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH)+1.
REQ-028 irq SHALL equal non-empty, updated in the cycle after the causing edge.

Reset
REQ-029 On rst: FIFO pointers, count, overflow, stable_press, debounce counter, in_code, in_press SHALL be 0; irq = 0; rdata reflects empty state (0x0000 for DATA and STATUS).
REQ-030 Reset mid-press SHALL not produce a push unless key_pressed subsequently stays 0 for a full debounce window before rising again.
REQ-031 FIFO storage contents need not be reset.

Configuration
REQ-032 Macro KEYPAD_DEBOUNCE_EN: defined -> debounce per REQ-015; undefined -> stable_press <= in_press every cycle, no counter logic synthesized, DEB_CYCLES unused.

Verification (DEB_CYCLES=4 in bench)
REQ-033 key_pressed=1, key_in=0x5 held 20 cycles -> exactly one push; STATUS = 0x0011, irq=1; DATA read returns 0x0005, then STATUS 0x0000, irq=0.
REQ-034 key_pressed toggling every 2 cycles for 20 cycles then low -> zero pushes (debounce on); with KEYPAD_DEBOUNCE_EN undefined -> one push per rising edge.
REQ-035 9 distinct presses (codes 0x1..0x9), no reads, DEPTH=8 -> STATUS = 0x0087; reads return 0x1..0x8 in order; 0x9 lost.
REQ-036 FIFO full, press completes on the same edge as a DATA read -> read returns oldest, new code appended, STATUS count stays 8, overflow stays 0.
REQ-037 Write STATUS 0x0005 with 3 entries and overflow set -> STATUS 0x0000, irq=0; next DATA read returns 0x0000.
REQ-038 rst asserted while 2 entries queued and key held -> STATUS 0x0000; no push until key released and re-pressed for a debounce window each.

Source files
------------

// File: rtl/keypad_fifo_ctrl.sv
// Keypad debounce + push-on-press FIFO behind a DATA/STATUS I/O window; KEYPAD_DEBOUNCE_EN enables the debounce counter.
// Latency: push on the debounced press edge (2 cycles undebounced, DEB_CYCLES+1 debounced); rdata is combinational.
// Backpressure: none upstream; a press into a full FIFO is dropped and sets the sticky overflow flag.
module keypad_fifo_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_in,
  input  logic        key_pressed,
  input  logic        cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic        addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    in_code_q;
  logic          in_press_q;
  logic          stable_press_q, stable_press_d;
  logic          push_req;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    mem_q [DEPTH];

  logic          empty, full, rd_hit, pop, push, flush, ovf_clr;
  logic [3:0]    cnt4;
  logic          unused_wdata;

  assign unused_wdata = ^{wdata[15:3], wdata[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      in_code_q      <= 4'h0;
      in_press_q     <= 1'b0;
      stable_press_q <= 1'b0;
    end else begin
      in_code_q      <= key_in;
      in_press_q     <= key_pressed;
      stable_press_q <= stable_press_d;
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  // arm_q blocks pushes after reset until the key has been seen released for a full window
  logic          arm_q, arm_d;

  always_comb begin
    stable_press_d = stable_press_q;
    deb_cnt_d      = '0;
    arm_d          = arm_q;
    if (in_press_q != stable_press_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        stable_press_d = in_press_q;
        if (!in_press_q) arm_d = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end else if (!arm_q && !in_press_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) arm_d = 1'b1;
      else deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      arm_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      arm_q     <= arm_d;
    end
  end

  assign push_req = arm_q && stable_press_d && !stable_press_q;
`else
  logic unused_deb;
  assign unused_deb     = (DEB_CYCLES > 0);
  assign stable_press_d = in_press_q;
  assign push_req       = in_press_q && !stable_press_q;
`endif

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign rd_hit  = cs && io_rd && !addr;
  assign pop     = rd_hit && !empty;
  assign flush   = cs && io_wr && addr && wdata[0];
  assign ovf_clr = cs && io_wr && addr && wdata[2];
  assign push    = push_req && !flush && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (ovf_clr) ovf_d = 1'b0;
    if (push_req && !flush && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code_q;
  end

  // With DEPTH=16 the 4-bit count field wraps to 0 when full; the full bit disambiguates
  assign cnt4 = 4'(count_q);

  always_comb begin
    rdata = 16'h0000;
    if (!addr) begin
      if (!empty) rdata = {12'h000, mem_q[rd_ptr_q]};
    end else begin
      rdata = {8'h00, cnt4, 1'b0, ovf_q, full, !empty};
    end
  end

  assign irq = !empty;

endmodule

// File: tb/tb_keypad_fifo_ctrl.sv
// Bench for keypad_fifo_ctrl: directed presses and register accesses; every read pushes its
// expected rdata/irq into a queue that a negedge monitor pops and compares.
module tb_keypad_fifo_ctrl;

  localparam int DEB   = 4;
  localparam int DEPTH = 8;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int LAT = DEB + 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_in;
  logic        key_pressed;
  logic        cs;
  logic        io_rd;
  logic        io_wr;
  logic        addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  keypad_fifo_ctrl #(.DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_pressed(key_pressed),
    .cs(cs), .io_rd(io_rd), .io_wr(io_wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq)
  );

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  string       name_q[$];
  logic [15:0] rdx_q[$];
  logic        irq_q[$];
  string       mon_nm;
  logic [15:0] mon_e;
  logic        mon_ei;

  always @(negedge clk) begin
    if (cs && io_rd) begin
      if (name_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_read rdata got=%h expected=none", rdata);
      end else begin
        mon_nm = name_q.pop_front();
        mon_e  = rdx_q.pop_front();
        mon_ei = irq_q.pop_front();
        total_cnt++;
        if (rdata === mon_e) pass_cnt++;
        else $display("FAIL %s rdata got=%h expected=%h", mon_nm, rdata, mon_e);
        total_cnt++;
        if (irq === mon_ei) pass_cnt++;
        else $display("FAIL %s irq got=%b expected=%b", mon_nm, irq, mon_ei);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic a, input logic [15:0] e, input logic ei, input string nm);
    cs = 1'b1; io_rd = 1'b1; addr = a;
    name_q.push_back(nm); rdx_q.push_back(e); irq_q.push_back(ei);
    tick(1);
    cs = 1'b0; io_rd = 1'b0; addr = 1'b0;
  endtask

  task automatic wr(input logic a, input logic [15:0] d);
    cs = 1'b1; io_wr = 1'b1; addr = a; wdata = d;
    tick(1);
    cs = 1'b0; io_wr = 1'b0; addr = 1'b0; wdata = 16'h0000;
  endtask

  task automatic press(input logic [3:0] code);
    key_in = code; key_pressed = 1'b1;
    tick(20);
    key_pressed = 1'b0;
    tick(20);
  endtask

  // The strobe is lined up with the edge on which the debounced press pushes
  task automatic press_sync_read(input logic [3:0] code, input logic [15:0] e, input logic ei, input string nm);
    key_in = code; key_pressed = 1'b1;
    tick(LAT - 1);
    rd(1'b0, e, ei, nm);
    tick(18);
    key_pressed = 1'b0;
    tick(20);
  endtask

  task automatic press_sync_flush(input logic [3:0] code);
    key_in = code; key_pressed = 1'b1;
    tick(LAT - 1);
    wr(1'b1, 16'h0001);
    tick(18);
    key_pressed = 1'b0;
    tick(20);
  endtask

  initial begin
    rst = 1'b1; key_in = 4'h0; key_pressed = 1'b0;
    cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0; addr = 1'b0; wdata = 16'h0000;
    tick(3);
    rst = 1'b0;
    rd(1'b1, 16'h0000, 1'b0, "rst_status");
    rd(1'b0, 16'h0000, 1'b0, "rst_data");
    tick(20);

    // single held key
    press(4'h5);
    rd(1'b1, 16'h0011, 1'b1, "hold_status");
    wr(1'b0, 16'hFFFF);
    rd(1'b1, 16'h0011, 1'b1, "data_wr_ignored");
    rd(1'b0, 16'h0005, 1'b1, "hold_data");
    rd(1'b1, 16'h0000, 1'b0, "hold_empty");

    // bouncing input
    key_in = 4'h3;
    for (int i = 0; i < 5; i++) begin
      key_pressed = 1'b1; tick(2);
      key_pressed = 1'b0; tick(2);
    end
    tick(20);
`ifdef KEYPAD_DEBOUNCE_EN
    rd(1'b1, 16'h0000, 1'b0, "bounce_status");
`else
    rd(1'b1, 16'h0051, 1'b1, "bounce_status");
`endif
    wr(1'b1, 16'h0001);
    rd(1'b1, 16'h0000, 1'b0, "bounce_flushed");

    // overfill: 0x9 is lost
    for (int c = 1; c <= 9; c++) press(4'(c));
    rd(1'b1, 16'h0087, 1'b1, "ovf_status");
    wr(1'b1, 16'h0004);
    rd(1'b1, 16'h0083, 1'b1, "ovf_cleared");

    // push and pop on the same edge while full
    press_sync_read(4'hA, 16'h0001, 1'b1, "full_pushpop_data");
    rd(1'b1, 16'h0083, 1'b1, "full_pushpop_status");
    for (int c = 2; c <= 8; c++) rd(1'b0, 16'(c), 1'b1, "drain");
    rd(1'b0, 16'h000A, 1'b1, "drain_new");
    rd(1'b0, 16'h0000, 1'b0, "drain_empty");
    rd(1'b1, 16'h0000, 1'b0, "drain_status");

    // push and pop on the same edge while empty
    press_sync_read(4'hB, 16'h0000, 1'b0, "empty_pushpop_data");
    rd(1'b1, 16'h0011, 1'b1, "empty_pushpop_status");

    // fill past full, drain to 3 entries, then flush + clear overflow together
    for (int i = 0; i < 8; i++) press(4'(12 + i));
    rd(1'b1, 16'h0087, 1'b1, "ovf2_status");
    for (int i = 0; i < 5; i++) rd(1'b0, 16'(11 + i), 1'b1, "ovf2_drain");
    rd(1'b1, 16'h0035, 1'b1, "three_ovf_status");
    wr(1'b1, 16'h0005);
    rd(1'b1, 16'h0000, 1'b0, "flush_status");
    rd(1'b0, 16'h0000, 1'b0, "flush_data");

    // flush on the push edge drops the key
    press_sync_flush(4'h6);
    rd(1'b1, 16'h0000, 1'b0, "flush_push_status");

    // reset with entries queued and a key held
    press(4'h1);
    press(4'h2);
    rd(1'b1, 16'h0021, 1'b1, "pre_rst_status");
    key_in = 4'h7; key_pressed = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rd(1'b1, 16'h0000, 1'b0, "rst_mid_status");
    tick(30);
`ifdef KEYPAD_DEBOUNCE_EN
    rd(1'b1, 16'h0000, 1'b0, "rst_held_status");
`else
    rd(1'b1, 16'h0011, 1'b1, "rst_held_status");
`endif
    key_pressed = 1'b0;
    tick(30);
    press(4'h8);
`ifdef KEYPAD_DEBOUNCE_EN
    rd(1'b1, 16'h0011, 1'b1, "repress_status");
`else
    rd(1'b1, 16'h0021, 1'b1, "repress_status");
    rd(1'b0, 16'h0007, 1'b1, "repress_held_data");
`endif
    rd(1'b0, 16'h0008, 1'b1, "repress_data");
    rd(1'b1, 16'h0000, 1'b0, "final_status");

    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
